// File: rtl/worker_batch_sched.sv
// -----------------------------------------------------------------------------
// worker_batch_sched
//   Sequences one worker through every sub-batch of every batch in a round.
//   Per sub-batch: one vid_sram read, Q dist_sram row reads (one per cycle,
//   addressed by the fetched vertex IDs), then a wait for worker_ready. After
//   the last sub-batch of a batch it waits for batch_finish before moving to
//   the next batch; after MAX_BATCH batches it pulses done.
//
// Ports
//   clk, rst_n            clock (posedge), asynchronous active-low reset
//   start                 one-cycle pulse, starts a round when idle
//   vid_raddr/vid_rdata   vid_sram read port (data one cycle after address)
//   dist_raddr            dist_sram row address
//   dist_rvalid           dist_rdata at the worker is valid this cycle
//   worker_en             worker enable
//   batch_num, sub_bat    current batch / sub-batch index
//   worker_ready          worker finished the current sub-batch
//   batch_finish          worker finished the current batch
//   busy, done            round in progress / one-cycle completion pulse
//   stall_cnt             (only with WORKER_SCHED_STALL_CNT_EN) count of
//                         cycles spent waiting in SWAIT or BWAIT
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module worker_batch_sched #(
  parameter int Q              = 16,
  parameter int VID_BW         = 16,
  parameter int VID_ADDR_SPACE = 4,
  parameter int BATCH_BW       = 8,
  parameter int MAX_BATCH      = 256,
  parameter int SUB_PER_BATCH  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic [VID_ADDR_SPACE-1:0] vid_raddr,
  input  logic [Q*VID_BW-1:0]       vid_rdata,
  output logic [VID_BW-1:0]         dist_raddr,
  output logic                      dist_rvalid,
  output logic                      worker_en,
  output logic [BATCH_BW-1:0]       batch_num,
  output logic [VID_ADDR_SPACE-1:0] sub_bat,
  input  logic                      worker_ready,
  input  logic                      batch_finish,
  output logic                      busy,
`ifdef WORKER_SCHED_STALL_CNT_EN
  output logic [31:0]               stall_cnt,
`endif
  output logic                      done
);

  localparam int KW = (Q > 1) ? $clog2(Q) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_VREQ, S_VWAIT, S_DISS, S_SWAIT, S_BWAIT, S_FIN
  } state_t;

  state_t                      state_q;
  logic [VID_ADDR_SPACE-1:0]   vid_raddr_q;
  logic [VID_BW-1:0]           dist_raddr_q;
  logic                        dist_rvalid_q;
  logic                        worker_en_q;
  logic [BATCH_BW-1:0]         batch_num_q;
  logic [VID_ADDR_SPACE-1:0]   sub_bat_q;
  logic                        busy_q;
  logic                        done_q;
  logic [KW-1:0]               k_q;
  logic [VID_BW-1:0]           vid_q [Q];
`ifdef WORKER_SCHED_STALL_CNT_EN
  logic [31:0]                 stall_cnt_q;
`endif

  logic [KW-1:0]               k_d;
  logic [BATCH_BW-1:0]         batch_num_d;
  logic [VID_ADDR_SPACE-1:0]   sub_bat_d;
  logic                        last_sub;
  logic                        last_batch;
  logic                        batch_adv;

  // vid_sram word address of a (batch, sub-batch) pair, truncated to the
  // address width.
  function automatic logic [VID_ADDR_SPACE-1:0] vid_addr(
    input logic [BATCH_BW-1:0]       b,
    input logic [VID_ADDR_SPACE-1:0] s
  );
    logic [31:0] a;
    a = 32'(b[VID_ADDR_SPACE-1:0]) * 32'(SUB_PER_BATCH) + 32'(s);
    return a[VID_ADDR_SPACE-1:0];
  endfunction

  assign k_d         = k_q + KW'(1);
  assign batch_num_d = batch_num_q + BATCH_BW'(1);
  assign sub_bat_d   = sub_bat_q + VID_ADDR_SPACE'(1);
  assign last_sub    = (sub_bat_q == VID_ADDR_SPACE'(SUB_PER_BATCH - 1));
  assign last_batch  = (batch_num_q == BATCH_BW'(MAX_BATCH - 1));
  // A batch_finish arriving together with the last worker_ready is consumed
  // right away, exactly as if BWAIT had been visited.
  assign batch_adv   = ((state_q == S_SWAIT) && worker_ready && last_sub && batch_finish) ||
                       ((state_q == S_BWAIT) && batch_finish);

  // Vertex-ID word is pure data: no reset needed.
  always_ff @(posedge clk) begin
    if (state_q == S_VWAIT) begin
      for (int i = 0; i < Q; i++) vid_q[i] <= vid_rdata[i*VID_BW +: VID_BW];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      vid_raddr_q   <= '0;
      dist_raddr_q  <= '0;
      dist_rvalid_q <= 1'b0;
      worker_en_q   <= 1'b0;
      batch_num_q   <= '0;
      sub_bat_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      k_q           <= '0;
`ifdef WORKER_SCHED_STALL_CNT_EN
      stall_cnt_q   <= '0;
`endif
    end else begin
      done_q        <= 1'b0;
      // Read data returns one cycle after each DISS address.
      dist_rvalid_q <= (state_q == S_DISS);
      case (state_q)
        S_IDLE: begin
          if (start) begin
            batch_num_q <= '0;
            sub_bat_q   <= '0;
            vid_raddr_q <= vid_addr('0, '0);
            busy_q      <= 1'b1;
            state_q     <= S_VREQ;
          end
        end
        S_VREQ:  state_q <= S_VWAIT;
        S_VWAIT: begin
          // Entry 0 goes straight from the SRAM so the first dist address
          // appears in the first DISS cycle.
          k_q          <= '0;
          dist_raddr_q <= vid_rdata[0 +: VID_BW];
          worker_en_q  <= 1'b1;
          state_q      <= S_DISS;
        end
        S_DISS: begin
          if (k_q == KW'(Q - 1)) begin
            state_q <= S_SWAIT;
          end else begin
            k_q          <= k_d;
            dist_raddr_q <= vid_q[k_d];
          end
        end
        S_SWAIT: begin
          if (worker_ready) begin
            if (last_sub) begin
              state_q <= S_BWAIT;
            end else begin
              sub_bat_q   <= sub_bat_d;
              vid_raddr_q <= vid_addr(batch_num_q, sub_bat_d);
              state_q     <= S_VREQ;
            end
          end
        end
        S_BWAIT: ;
        S_FIN: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      // Batch advance overrides the SWAIT -> BWAIT step above.
      if (batch_adv) begin
        sub_bat_q <= '0;
        if (last_batch) begin
          worker_en_q <= 1'b0;
          done_q      <= 1'b1;
          state_q     <= S_FIN;
        end else begin
          batch_num_q <= batch_num_d;
          vid_raddr_q <= vid_addr(batch_num_d, '0);
          state_q     <= S_VREQ;
        end
      end

`ifdef WORKER_SCHED_STALL_CNT_EN
      // Only cycles actually waiting on the worker count as stalls.
      if ((state_q == S_IDLE) && start) begin
        stall_cnt_q <= '0;
      end else if ((((state_q == S_SWAIT) && !worker_ready) ||
                    ((state_q == S_BWAIT) && !batch_finish)) && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
`endif
    end
  end

  assign vid_raddr   = vid_raddr_q;
  assign dist_raddr  = dist_raddr_q;
  assign dist_rvalid = dist_rvalid_q;
  assign worker_en   = worker_en_q;
  assign batch_num   = batch_num_q;
  assign sub_bat     = sub_bat_q;
  assign busy        = busy_q;
  assign done        = done_q;
`ifdef WORKER_SCHED_STALL_CNT_EN
  assign stall_cnt   = stall_cnt_q;
`endif

endmodule

// File: tb/tb_worker_batch_sched.sv
`timescale 1ns/1ps
module tb_worker_batch_sched;

  localparam int Q  = 16;
  localparam int VB = 16;
  localparam int VA = 4;
  localparam int BB = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            start = 1'b0;
  logic [VA-1:0]   vid_raddr;
  logic [Q*VB-1:0] vid_rdata = '0;
  logic [VB-1:0]   dist_raddr;
  logic            dist_rvalid;
  logic            worker_en;
  logic [BB-1:0]   batch_num;
  logic [VA-1:0]   sub_bat;
  logic            worker_ready = 1'b0;
  logic            batch_finish = 1'b0;
  logic            busy;
  logic            done;
`ifdef WORKER_SCHED_STALL_CNT_EN
  logic [31:0]     stall_cnt;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  worker_batch_sched dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .vid_raddr    (vid_raddr),
    .vid_rdata    (vid_rdata),
    .dist_raddr   (dist_raddr),
    .dist_rvalid  (dist_rvalid),
    .worker_en    (worker_en),
    .batch_num    (batch_num),
    .sub_bat      (sub_bat),
    .worker_ready (worker_ready),
    .batch_finish (batch_finish),
    .busy         (busy),
`ifdef WORKER_SCHED_STALL_CNT_EN
    .stall_cnt    (stall_cnt),
`endif
    .done         (done)
  );

  always #5 clk = ~clk;

  // vid_sram model: word a holds vids a*16+k, so word 0 holds 0..15.
  function automatic logic [Q*VB-1:0] vid_word(input logic [VA-1:0] a);
    logic [Q*VB-1:0] w;
    for (int k = 0; k < Q; k++) w[k*VB +: VB] = VB'(32'(a) * 16 + k);
    return w;
  endfunction

  always @(posedge clk) vid_rdata <= vid_word(vid_raddr);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int bursts, seq_err, inc_err, prev_b;
    logic prev_rv, got_done, pulsed;

    // ---------------- reset ----------------
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vid_raddr", vid_raddr, 0);
    chk("rst_dist_raddr", dist_raddr, 0);
    chk("rst_dist_rvalid", dist_rvalid, 0);
    chk("rst_worker_en", worker_en, 0);
    chk("rst_batch_num", batch_num, 0);
    chk("rst_sub_bat", sub_bat, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_busy", busy, 0);

    // ---------------- first sub-batch dist sequence, then SWAIT stall ----------------
    start = 1'b1;
    tick();                          // E0 -> VREQ
    start = 1'b0;
    chk("start_busy", busy, 1);
    tick();                          // E1 -> VWAIT
    tick();                          // E2 -> DISS k=0
    for (int i = 0; i < Q; i++) begin
      chk("dist_raddr_seq", dist_raddr, 64'(i));
      chk("dist_rvalid_seq", dist_rvalid, (i != 0) ? 64'd1 : 64'd0);
      if (i == 0) chk("diss_worker_en", worker_en, 1);
      tick();
    end
    chk("rvalid_tail", dist_rvalid, 1);
    chk("dist_raddr_hold", dist_raddr, 15);
    tick();                          // first SWAIT stall edge
    chk("rvalid_off", dist_rvalid, 0);
    repeat (49) tick();              // 50 stalled SWAIT edges in total
    chk("stall_sub_bat", sub_bat, 0);
    chk("stall_vid_raddr", vid_raddr, 0);
    chk("stall_worker_en", worker_en, 1);
    chk("stall_busy", busy, 1);
`ifdef WORKER_SCHED_STALL_CNT_EN
    chk("stall_cnt_swait", stall_cnt, 50);
`endif
    worker_ready = 1'b1;
    tick();
    chk("adv_sub_bat", sub_bat, 1);
    chk("adv_vid_raddr", vid_raddr, 1);
    tick();
    tick();
    tick();                          // second DISS cycle of sub-batch 1
    chk("pre_rst_rvalid", dist_rvalid, 1);

    // ---------------- asynchronous reset mid-DISS ----------------
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_rvalid", dist_rvalid, 0);
    chk("midrst_outputs", {vid_raddr, dist_raddr, worker_en, batch_num, sub_bat, busy, done}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ---------------- full round, worker_ready and batch_finish tied high ----------------
    worker_ready = 1'b1;
    batch_finish = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_batch", batch_num, 0);
    chk("restart_sub", sub_bat, 0);
    chk("restart_vid", vid_raddr, 0);
    bursts = 0; seq_err = 0; inc_err = 0; prev_b = 0;
    prev_rv = 1'b0; got_done = 1'b0; pulsed = 1'b0;
    for (int c = 0; c < 80000 && !got_done; c++) begin
      tick();
      if (start) begin
        start = 1'b0;
        chk("busy_start_batch", batch_num, 3);
        chk("busy_start_sub", sub_bat, 5);
        chk("busy_start_busy", busy, 1);
      end
      if (dist_rvalid && !prev_rv) begin
        if (32'(vid_raddr) != bursts % 16 || 32'(sub_bat) != bursts % 16 ||
            32'(batch_num) != bursts / 16) seq_err++;
        bursts++;
        if (bursts == 3 * 16 + 6 && !pulsed) begin
          start  = 1'b1;             // start while busy in batch 3
          pulsed = 1'b1;
        end
      end
      if (32'(batch_num) != prev_b) begin
        if (32'(batch_num) != prev_b + 1) inc_err++;
        prev_b = 32'(batch_num);
      end
      prev_rv = dist_rvalid;
      if (done) begin
        got_done = 1'b1;
        chk("done_batch_num", batch_num, 255);
        chk("done_busy", busy, 1);
        chk("done_worker_en", worker_en, 0);
      end
    end
    chk("round_done", got_done, 1);
    chk("round_bursts", 64'(bursts), 4096);
    chk("round_vid_seq_errs", 64'(seq_err), 0);
    chk("round_batch_step_errs", 64'(inc_err), 0);
    tick();
    chk("after_done_busy", busy, 0);
    chk("after_done_pulse", done, 0);
    chk("after_done_batch", batch_num, 255);

    // ---------------- BWAIT: batch_finish late ----------------
    batch_finish = 1'b0;
    start = 1'b1;
    tick();                          // E0
    start = 1'b0;
    repeat (310) tick();             // BWAIT entered at E304
    chk("bwait_batch", batch_num, 0);
    chk("bwait_sub", sub_bat, 15);
    chk("bwait_worker_en", worker_en, 1);
    chk("bwait_busy", busy, 1);
`ifdef WORKER_SCHED_STALL_CNT_EN
    chk("stall_cnt_bwait", stall_cnt, 6);
`endif
    batch_finish = 1'b1;
    tick();
    batch_finish = 1'b0;
    chk("bfin_batch", batch_num, 1);
    chk("bfin_sub", sub_bat, 0);
    chk("bfin_vid", vid_raddr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/worker_batch_sched.md
Name: worker_batch_sched

Overview:
- Sequencer that drives one `worker` through every batch and every sub-batch of a round.
- Per sub-batch it does three things:
  - reads one vid_sram word (Q vertex IDs);
  - issues Q dist_sram row reads addressed by those vids, one per cycle, with a qualifying valid to the worker;
  - waits for the worker's `ready` before advancing.
- After the last sub-batch of a batch it waits for `batch_finish`, increments `batch_num`, and repeats until MAX_BATCH batches are done.
- Sits between the top-level start/done control and the worker plus its vid/dist SRAMs.

Parameters:
- Q, 16, vertex IDs per vid_sram word and dist reads per sub-batch
- VID_BW, 16, vertex ID width; also the dist_sram row address width
- VID_ADDR_SPACE, 4, vid_sram address width
- BATCH_BW, 8, batch counter width
- MAX_BATCH, 256, batches per round
- SUB_PER_BATCH, 16, sub-batches per batch (power of two, at most 2^VID_ADDR_SPACE)

Ports:
- clk  in  1  clock, all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begins a round when IDLE, ignored otherwise
- vid_raddr  out  VID_ADDR_SPACE  vid_sram read address
- vid_rdata  in  Q*VID_BW  vid_sram data, valid 1 cycle after the address
- dist_raddr  out  VID_BW  dist_sram row address
- dist_rvalid  out  1  dist_rdata at the worker is valid this cycle
- worker_en  out  1  enable to the worker
- batch_num  out  BATCH_BW  current batch, to the worker
- sub_bat  out  VID_ADDR_SPACE  current sub-batch index
- worker_ready  in  1  worker finished its part[] for the current sub-batch
- batch_finish  in  1  worker finished next/proposal writes for the batch
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on completion of a round

Behaviour:
- Reset values: all counters and outputs 0; FSM in IDLE.
- States: IDLE, VREQ, VWAIT, DISS, SWAIT, BWAIT, FIN.
- IDLE:
  - on `start`: batch_num=0, sub_bat=0, go to VREQ.
- VREQ:
  - vid_raddr = batch_num[VID_ADDR_SPACE-1:0]*SUB_PER_BATCH + sub_bat (truncated to VID_ADDR_SPACE).
  - Go to VWAIT.
- VWAIT:
  - Latch vid_rdata into an internal Q-entry vid register; clear index k=0.
  - Go to DISS.
- DISS (exactly Q cycles):
  - dist_raddr = vid_reg[k] (entry k is bits k*VID_BW +: VID_BW).
  - k increments each cycle.
  - Leave for SWAIT when k==Q-1.
- dist_rvalid:
  - registered copy of "in DISS", so it is high the cycle after each address: exactly Q cycles, lagging dist_raddr by one.
- worker_en:
  - asserted from the first DISS cycle; stays high through SWAIT and BWAIT; deasserted in IDLE and FIN.
- SWAIT:
  - Wait for worker_ready.
  - If sub_bat==SUB_PER_BATCH-1, go to BWAIT.
  - Otherwise sub_bat++ and go to VREQ.
  - worker_ready in any state other than SWAIT is ignored.
- BWAIT:
  - On batch_finish, sub_bat=0.
  - If batch_num==MAX_BATCH-1, go to FIN.
  - Otherwise batch_num++ and go to VREQ.
- Simultaneous worker_ready and batch_finish in SWAIT of the last sub-batch:
  - go directly to FIN / next batch as if BWAIT had been visited; the batch_finish is consumed, not lost.
- FIN:
  - done=1 for one cycle, then IDLE.
  - batch_num and sub_bat hold their final values until the next start.
- start while busy is ignored.
- Reset mid-round (async):
  - immediately returns to IDLE with all outputs 0.
  - A dist read in flight is discarded (dist_rvalid=0).
- Wrap-around: batch_num counts 0..MAX_BATCH-1 with no overflow; MAX_BATCH equal to 2^BATCH_BW is legal.
- Latency, start to first dist_raddr: 3 cycles (IDLE→VREQ→VWAIT→DISS).
- Minimum sub-batch period: Q+3 cycles plus the worker_ready wait.

Optional Feature:
- Macro: WORKER_SCHED_STALL_CNT_EN.
- When defined:
  - extra output `stall_cnt`, 32 bits;
  - counts cycles spent in SWAIT or BWAIT;
  - cleared on start, saturates at all-ones, holds after done.
- When undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset, then start with worker_ready and batch_finish tied high:
  - vid_raddr sequence 0..15, 16 DISS bursts per batch;
  - done pulses after 256 batches;
  - batch_num ends at 255, busy drops the cycle after done.
- vid word holding vids 0x0000..0x000F, sub-batch 0:
  - dist_raddr = 0,1,..,15 on consecutive cycles;
  - dist_rvalid high for exactly 16 cycles, one cycle behind.
- worker_ready held low for 50 cycles in SWAIT:
  - sub_bat holds, no new vid_raddr issued;
  - stall_cnt (macro on) = 50.
- worker_ready and batch_finish high in the same cycle on sub_bat 15 → batch_num increments by exactly 1 with no hang.
- Pulse start while busy during batch 3 → no restart, counters unaffected.
- Assert rst_n=0 mid-DISS → all outputs 0 immediately; a new start afterwards resumes at batch 0, sub_bat 0.
